// File: rtl/uart_pkg.sv
// Shared types and constants for the two-requester UART transmit scheduler.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      WAIT_BUSY,
      WAIT_DONE,
      GAP
   } state_t;

   // Channel ids share the polarity of uart_sel.
   localparam logic CH_A = 1'b1;
   localparam logic CH_B = 1'b0;

   localparam int unsigned DATA_W            = 8;
   localparam int unsigned FRAME_CNT_W       = 16;
   localparam int unsigned DEF_STROBE_CYCLES = 4;
   localparam int unsigned DEF_BUSY_TIMEOUT  = 4096;
   localparam int unsigned DEF_GAP_CYCLES    = 16;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/uart_tx_sched_req_buf.sv
// One-deep capture buffer with req/ack handshake; holds its byte until cleared.
module uart_req_buf
   import uart_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic [DATA_W-1:0] data,
   input  logic              clr,
   output logic              full,
   output logic [DATA_W-1:0] data_q,
   output logic              ack
);

   // A full buffer ignores req, so the byte under transmission stays frozen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full   <= 1'b0;
         data_q <= '0;
         ack    <= 1'b0;
      end else begin
         ack <= 1'b0;
         if (clr) begin
            full <= 1'b0;
         end else if (req && !full) begin
            full   <= 1'b1;
            data_q <= data;
            ack    <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Arbitrates two byte requesters onto a shared UART: select, strobe, busy tracking, timeout.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int unsigned STROBE_CYCLES = DEF_STROBE_CYCLES,
   parameter int unsigned BUSY_TIMEOUT  = DEF_BUSY_TIMEOUT,
   parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_a,
   input  logic [DATA_W-1:0]      data_a,
   output logic                   ack_a,
   input  logic                   req_b,
   input  logic [DATA_W-1:0]      data_b,
   output logic                   ack_b,
   input  logic                   prio_mode,
   input  logic                   uart_busy,
   output logic                   uart_wrsig,
   output logic                   uart_sel,
   output logic [DATA_W-1:0]      uart_data_1,
   output logic [DATA_W-1:0]      uart_data_2,
   output logic                   timeout_err,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   localparam int unsigned MAX_SG = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
   localparam int unsigned MAX_CNT = (BUSY_TIMEOUT > MAX_SG) ? BUSY_TIMEOUT : MAX_SG;
   localparam int unsigned CNT_W = cnt_width(MAX_CNT);

   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STROBE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam state_t POST_ST = (GAP_CYCLES == 0) ? IDLE : GAP;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             rr_q;
   logic             full_a;
   logic             full_b;
   logic             grant_c;
   logic             tout_c;
   logic             done_c;
   logic             clr_a_c;
   logic             clr_b_c;

   uart_req_buf u_buf_a (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req_a),
      .data   (data_a),
      .clr    (clr_a_c),
      .full   (full_a),
      .data_q (uart_data_1),
      .ack    (ack_a)
   );

   uart_req_buf u_buf_b (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req_b),
      .data   (data_b),
      .clr    (clr_b_c),
      .full   (full_b),
      .data_q (uart_data_2),
      .ack    (ack_b)
   );

   // Grant choice and end-of-frame buffer release; uart_sel holds the active grant.
   always_comb begin
      grant_c = CH_B;
      tout_c  = 1'b0;
      done_c  = 1'b0;
      if (full_a && (!full_b || prio_mode || rr_q == CH_A)) begin
         grant_c = CH_A;
      end
      tout_c  = (state_q == WAIT_BUSY) && !uart_busy && (cnt_q == TMO_LAST);
      done_c  = (state_q == WAIT_DONE) && !uart_busy;
      clr_a_c = (tout_c || done_c) && (uart_sel == CH_A);
      clr_b_c = (tout_c || done_c) && (uart_sel == CH_B);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rr_q        <= CH_A;
         uart_sel    <= CH_A;
         uart_wrsig  <= 1'b0;
         timeout_err <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         timeout_err <= 1'b0;
         unique case (state_q)
            IDLE: begin
               // A stale frame from before reset must drain before granting.
               if (!uart_busy && (full_a || full_b)) begin
                  uart_sel <= grant_c;
                  state_q  <= SETUP;
               end
            end
            SETUP: begin
               uart_wrsig <= 1'b1;
               cnt_q      <= '0;
               state_q    <= STROBE;
            end
            STROBE: begin
               if (cnt_q == STB_LAST) begin
                  uart_wrsig <= 1'b0;
                  cnt_q      <= '0;
                  state_q    <= WAIT_BUSY;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            WAIT_BUSY: begin
               if (uart_busy) begin
                  state_q <= WAIT_DONE;
               end else if (tout_c) begin
                  timeout_err <= 1'b1;
                  rr_q        <= ~uart_sel;
                  cnt_q       <= '0;
                  state_q     <= POST_ST;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            WAIT_DONE: begin
               if (done_c) begin
                  frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
                  rr_q      <= ~uart_sel;
                  cnt_q     <= '0;
                  state_q   <= POST_ST;
               end
            end
            GAP: begin
               if (cnt_q == GAP_LAST) begin
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched with a scripted transmitter busy model.
module tb_uart_tx_sched;
   import uart_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_a, req_b, prio_mode, uart_busy;
   logic [7:0]  data_a, data_b;
   logic        ack_a, ack_b, uart_wrsig, uart_sel, timeout_err;
   logic [7:0]  uart_data_1, uart_data_2;
   logic [15:0] frame_cnt;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   uart_tx_sched dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_a       (req_a),
      .data_a      (data_a),
      .ack_a       (ack_a),
      .req_b       (req_b),
      .data_b      (data_b),
      .ack_b       (ack_b),
      .prio_mode   (prio_mode),
      .uart_busy   (uart_busy),
      .uart_wrsig  (uart_wrsig),
      .uart_sel    (uart_sel),
      .uart_data_1 (uart_data_1),
      .uart_data_2 (uart_data_2),
      .timeout_err (timeout_err),
      .frame_cnt   (frame_cnt)
   );

   task automatic push(input logic ch, input logic [7:0] d, output logic ok);
      int n = 0;
      if (ch == CH_A) begin req_a = 1'b1; data_a = d; end
      else begin req_b = 1'b1; data_b = d; end
      ok = 1'b0;
      while (!ok && n < 64) begin
         @(negedge clk);
         n++;
         ok = (ch == CH_A) ? ack_a : ack_b;
      end
      if (ch == CH_A) req_a = 1'b0;
      else req_b = 1'b0;
   endtask

   // Waits for a strobe, records what it carried, then plays busy high/low.
   task automatic serve_frame(input int rise_dly, input int hold, output logic sel_s,
                              output logic [7:0] d1_s, output logic [7:0] d2_s,
                              output int hi_len, output int wait_n, output logic ok);
      wait_n = 0;
      hi_len = 0;
      sel_s  = 1'bx;
      d1_s   = 8'hxx;
      d2_s   = 8'hxx;
      while (!uart_wrsig && wait_n < 20000) begin
         @(negedge clk);
         wait_n++;
      end
      ok = uart_wrsig;
      if (!ok) return;
      sel_s = uart_sel;
      d1_s  = uart_data_1;
      d2_s  = uart_data_2;
      while (uart_wrsig && hi_len < 64) begin
         @(negedge clk);
         hi_len++;
      end
      repeat (rise_dly - hi_len) @(negedge clk);
      uart_busy = 1'b1;
      repeat (hold) @(negedge clk);
      uart_busy = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_a = 1'b0; req_b = 1'b0; data_a = '0; data_b = '0;
      prio_mode = 1'b0; uart_busy = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_a = 1'b0; req_b = 1'b0; data_a = 8'hFF; data_b = 8'hFF;
      prio_mode = 1'b0; uart_busy = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({uart_wrsig, uart_sel, ack_a, ack_b, timeout_err} !== 5'b01000) begin
         errors++;
         $display("FAIL reset_ctl: got wrsig/sel/ack_a/ack_b/tmo=%b expected 01000",
                  {uart_wrsig, uart_sel, ack_a, ack_b, timeout_err});
      end
      checks++;
      if ({uart_data_1, uart_data_2, frame_cnt} !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: got d1=%h d2=%h cnt=%h expected zeros",
                  uart_data_1, uart_data_2, frame_cnt);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      logic s; logic [7:0] d1, d2; int hi, wn; logic ok;
      do_reset();
      req_a = 1'b1; data_a = 8'h11; req_b = 1'b1; data_b = 8'h22;
      @(negedge clk);
      req_a = 1'b0; req_b = 1'b0;
      checks++;
      if ({ack_a, ack_b} !== 2'b11) begin
         errors++;
         $display("FAIL rr_acks: got %b expected 11", {ack_a, ack_b});
      end
      serve_frame(20, 180, s, d1, d2, hi, wn, ok);
      checks++;
      if (!ok || s !== 1'b1 || d1 !== 8'h11) begin
         errors++;
         $display("FAIL rr_first: got ok=%b sel=%b d1=%h expected 1 1 11", ok, s, d1);
      end
      serve_frame(20, 180, s, d1, d2, hi, wn, ok);
      checks++;
      if (!ok || s !== 1'b0 || d2 !== 8'h22) begin
         errors++;
         $display("FAIL rr_second: got ok=%b sel=%b d2=%h expected 1 0 22", ok, s, d2);
      end
      checks++;
      if (wn < 16) begin
         errors++;
         $display("FAIL rr_gap: got %0d idle cycles expected >=16", wn);
      end
      @(negedge clk);
      checks++;
      if (frame_cnt !== 16'd2) begin
         errors++;
         $display("FAIL rr_count: got %0d expected 2", frame_cnt);
      end
   endtask

   task automatic test_single_byte();
      logic s; logic [7:0] d1, d2; int hi, wn; logic ok;
      repeat (25) @(negedge clk);
      req_a = 1'b1; data_a = 8'h5A;
      @(negedge clk);
      req_a = 1'b0;
      checks++;
      if (ack_a !== 1'b1) begin
         errors++;
         $display("FAIL single_ack_hi: got %b expected 1", ack_a);
      end
      @(negedge clk);
      checks++;
      if (ack_a !== 1'b0) begin
         errors++;
         $display("FAIL single_ack_pulse: got %b expected 0", ack_a);
      end
      serve_frame(20, 180, s, d1, d2, hi, wn, ok);
      checks++;
      if (!ok || s !== 1'b1 || d1 !== 8'h5A) begin
         errors++;
         $display("FAIL single_frame: got ok=%b sel=%b d1=%h expected 1 1 5a", ok, s, d1);
      end
      checks++;
      if (hi !== 4) begin
         errors++;
         $display("FAIL single_strobe_len: got %0d expected 4", hi);
      end
      @(negedge clk);
      checks++;
      if (frame_cnt !== 16'd3) begin
         errors++;
         $display("FAIL single_count: got %0d expected 3", frame_cnt);
      end
   endtask

   task automatic test_fixed_priority();
      logic s; logic [7:0] d1, d2; int hi, wn; logic ok;
      logic [7:0] a_bytes [3];
      a_bytes[0] = 8'hA1; a_bytes[1] = 8'hA2; a_bytes[2] = 8'hA3;
      repeat (25) @(negedge clk);
      prio_mode = 1'b1;
      req_a = 1'b1; data_a = a_bytes[0]; req_b = 1'b1; data_b = 8'h33;
      @(negedge clk);
      req_a = 1'b0; req_b = 1'b0;
      for (int i = 0; i < 3; i++) begin
         serve_frame(20, 60, s, d1, d2, hi, wn, ok);
         checks++;
         if (!ok || s !== 1'b1 || d1 !== a_bytes[i]) begin
            errors++;
            $display("FAIL prio_a%0d: got ok=%b sel=%b d1=%h expected 1 1 %h", i, ok, s, d1, a_bytes[i]);
         end
         if (i < 2) push(CH_A, a_bytes[i+1], ok);
      end
      serve_frame(20, 60, s, d1, d2, hi, wn, ok);
      checks++;
      if (!ok || s !== 1'b0 || d2 !== 8'h33) begin
         errors++;
         $display("FAIL prio_b: got ok=%b sel=%b d2=%h expected 1 0 33", ok, s, d2);
      end
      prio_mode = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      logic s; logic [7:0] d1, d2; int hi, wn, n, cyc; logic ok, ok2;
      logic [15:0] fc;
      repeat (25) @(negedge clk);
      fc = frame_cnt;
      push(CH_A, 8'h77, ok);
      n = 0;
      while (!uart_wrsig && n < 100) begin @(negedge clk); n++; end
      while (uart_wrsig && n < 200) begin @(negedge clk); n++; end
      cyc = 0;
      while (!timeout_err && cyc < 5000) begin @(negedge clk); cyc++; end
      checks++;
      if (cyc !== 4096) begin
         errors++;
         $display("FAIL tmo_latency: got %0d cycles expected 4096", cyc);
      end
      @(negedge clk);
      checks++;
      if (timeout_err !== 1'b0 || frame_cnt !== fc) begin
         errors++;
         $display("FAIL tmo_pulse_cnt: got tmo=%b cnt=%0d expected 0 %0d", timeout_err, frame_cnt, fc);
      end
      push(CH_B, 8'h44, ok);
      push(CH_A, 8'h78, ok2);
      checks++;
      if ({ok, ok2} !== 2'b11) begin
         errors++;
         $display("FAIL tmo_recapture: got acks %b expected 11", {ok, ok2});
      end
      serve_frame(20, 60, s, d1, d2, hi, wn, ok);
      checks++;
      if (!ok || s !== 1'b0 || d2 !== 8'h44) begin
         errors++;
         $display("FAIL tmo_next_b: got ok=%b sel=%b d2=%h expected 1 0 44", ok, s, d2);
      end
      serve_frame(20, 60, s, d1, d2, hi, wn, ok);
      checks++;
      if (!ok || s !== 1'b1 || d1 !== 8'h78) begin
         errors++;
         $display("FAIL tmo_next_a: got ok=%b sel=%b d1=%h expected 1 1 78", ok, s, d1);
      end
      @(negedge clk);
      checks++;
      if (frame_cnt !== fc + 16'd2) begin
         errors++;
         $display("FAIL tmo_count: got %0d expected %0d", frame_cnt, fc + 16'd2);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic s; logic [7:0] d1, d2; int hi, wn, n; logic ok, seen;
      repeat (25) @(negedge clk);
      push(CH_B, 8'h55, ok);
      n = 0;
      while (!uart_wrsig && n < 100) begin @(negedge clk); n++; end
      while (uart_wrsig && n < 200) begin @(negedge clk); n++; end
      uart_busy = 1'b1;
      repeat (5) @(negedge clk);
      push(CH_A, 8'hAA, ok);
      checks++;
      if (ok !== 1'b1 || uart_sel !== 1'b0) begin
         errors++;
         $display("FAIL mid_setup: got ack=%b sel=%b expected 1 0", ok, uart_sel);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({uart_wrsig, uart_sel, timeout_err} !== 3'b010 ||
          {uart_data_1, uart_data_2, frame_cnt} !== 32'h0) begin
         errors++;
         $display("FAIL mid_async_reset: got wrsig=%b sel=%b d1=%h d2=%h cnt=%h expected 0 1 00 00 0000",
                  uart_wrsig, uart_sel, uart_data_1, uart_data_2, frame_cnt);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push(CH_A, 8'h66, ok);
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (uart_wrsig) seen = 1'b1;
      end
      checks++;
      if (ok !== 1'b1 || seen !== 1'b0) begin
         errors++;
         $display("FAIL mid_hold_busy: got ack=%b strobe=%b expected 1 0", ok, seen);
      end
      uart_busy = 1'b0;
      serve_frame(20, 60, s, d1, d2, hi, wn, ok);
      @(negedge clk);
      checks++;
      if (!ok || s !== 1'b1 || d1 !== 8'h66 || uart_data_2 !== 8'h00 || frame_cnt !== 16'd1) begin
         errors++;
         $display("FAIL mid_after: got ok=%b sel=%b d1=%h d2=%h cnt=%0d expected 1 1 66 00 1",
                  ok, s, d1, uart_data_2, frame_cnt);
      end
   endtask

   task automatic test_stale_busy_wrap();
      logic s; logic [7:0] d1, d2; int hi, wn; logic ok, seen;
      uart_busy = 1'b1;
      push(CH_A, 8'h99, ok);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (uart_wrsig) seen = 1'b1;
      end
      checks++;
      if (ok !== 1'b1 || seen !== 1'b0) begin
         errors++;
         $display("FAIL stale_hold: got ack=%b strobe=%b expected 1 0", ok, seen);
      end
      force dut.frame_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.frame_cnt;
      @(negedge clk);
      uart_busy = 1'b0;
      serve_frame(20, 60, s, d1, d2, hi, wn, ok);
      @(negedge clk);
      checks++;
      if (!ok || s !== 1'b1 || d1 !== 8'h99 || frame_cnt !== 16'h0000) begin
         errors++;
         $display("FAIL stale_wrap: got ok=%b sel=%b d1=%h cnt=%h expected 1 1 99 0000",
                  ok, s, d1, frame_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single_byte();
      test_fixed_priority();
      test_timeout();
      test_reset_mid_frame();
      test_stale_busy_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
